// File: rtl/sti_rx_if.sv
// ---------------------------------------------------------------------------
// sti_rx_if
// Bundles the STI receiver signals: the serial input stream, the frame
// configuration and the decoded word outputs.
//   master : serial source / configuration owner (drives si_*, cfg_*)
//   slave  : the sti_rx receiver (drives po_*, busy)
// Signals:
//   si_data, si_valid  serial bit and its qualifier
//   cfg_length         00=8, 01=16, 10=24, 11=32 bit frames
//   cfg_msb            1=MSB first, 0=LSB first
//   cfg_low            8-bit frames: 1=payload is high byte
//   cfg_fill           24/32-bit frames: 1=payload in top 16 bits
//   po_data            reconstructed 16-bit word
//   po_valid, po_err   one-cycle strobes (word ready / frame bad)
//   busy               frame in progress
// ---------------------------------------------------------------------------
interface sti_rx_if;
  logic        si_data;
  logic        si_valid;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic        cfg_low;
  logic        cfg_fill;
  logic [15:0] po_data;
  logic        po_valid;
  logic        po_err;
  logic        busy;

  modport master (
    output si_data, si_valid, cfg_length, cfg_msb, cfg_low, cfg_fill,
    input  po_data, po_valid, po_err, busy
  );

  modport slave (
    input  si_data, si_valid, cfg_length, cfg_msb, cfg_low, cfg_fill,
    output po_data, po_valid, po_err, busy
  );
endinterface

// File: rtl/sti_rx.sv
// ---------------------------------------------------------------------------
// sti_rx
// Receiving end of the STI serial link. Collects an 8/16/24/32-bit frame
// from the si_data/si_valid stream and rebuilds the 16-bit payload word.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    sti_rx_if.slave (serial input, cfg_*, po_data/po_valid/po_err/busy)
// Configuration is latched on the first bit of each frame.
// Optional build macro STI_RX_PADCHECK_EN: when defined, nonzero pad bits
// of 24/32-bit frames raise po_err together with po_valid.
// ---------------------------------------------------------------------------
module sti_rx (
  input logic     clk,
  input logic     reset,
  sti_rx_if.slave bus
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [31:0] shift_reg, shift_next;
  logic [1:0]  len_reg, len_next;
  logic        msb_reg, msb_next;
  logic        low_reg, low_next;
  logic        fill_reg, fill_next;
  logic [15:0] data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        err_reg, err_next;

  // Frame decode, evaluated on the shift value that includes the current bit.
  logic [2:0]  len_plus;
  logic [5:0]  n_bits;
  logic [31:0] shift_in;
  logic [31:0] shift_rev;
  logic [31:0] word;
  logic [15:0] payload;

  assign len_plus = {1'b0, len_reg} + 3'd1;
  assign n_bits   = {len_plus, 3'b000};
  assign shift_in = {shift_reg[30:0], bus.si_data};

  // The first received bit sits at shift_in[N-1]; for LSB-first frames it
  // must land at W[0], so reverse all 32 bits and drop the unused top part.
  for (genvar gi = 0; gi < 32; gi++) begin : g_rev
    assign shift_rev[gi] = shift_in[31-gi];
  end

  assign word = msb_reg ? shift_in : (shift_rev >> (6'd32 - n_bits));

  always_comb begin
    payload = 16'h0000;
    case (len_reg)
      2'b00:   payload = low_reg ? {word[7:0], 8'h00} : {8'h00, word[7:0]};
      2'b01:   payload = word[15:0];
      2'b10:   payload = fill_reg ? word[23:8]  : word[15:0];
      default: payload = fill_reg ? word[31:16] : word[15:0];
    endcase
  end

`ifdef STI_RX_PADCHECK_EN
  logic pad_bad;
  always_comb begin
    pad_bad = 1'b0;
    case (len_reg)
      2'b10:   pad_bad = fill_reg ? (word[7:0]   != 8'h00)   : (word[23:16] != 8'h00);
      2'b11:   pad_bad = fill_reg ? (word[15:0]  != 16'h0000) : (word[31:16] != 16'h0000);
      default: pad_bad = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      len_reg   <= '0;
      msb_reg   <= 1'b0;
      low_reg   <= 1'b0;
      fill_reg  <= 1'b0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      len_reg   <= len_next;
      msb_reg   <= msb_next;
      low_reg   <= low_next;
      fill_reg  <= fill_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    len_next   = len_reg;
    msb_next   = msb_reg;
    low_next   = low_reg;
    fill_next  = fill_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.si_valid) begin
          len_next   = bus.cfg_length;
          msb_next   = bus.cfg_msb;
          low_next   = bus.cfg_low;
          fill_next  = bus.cfg_fill;
          shift_next = {31'd0, bus.si_data};
          cnt_next   = 6'd1;
          state_next = RECV;
        end
      end
      default: begin
        if (bus.si_valid) begin
          shift_next = shift_in;
          cnt_next   = cnt_reg + 6'd1;
          if (cnt_reg + 6'd1 == n_bits) begin
            data_next  = payload;
            valid_next = 1'b1;
`ifdef STI_RX_PADCHECK_EN
            err_next   = pad_bad;
`endif
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
          // Truncated frame: drop it, keep the last delivered word.
          err_next   = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
    endcase
  end

  assign bus.po_data  = data_reg;
  assign bus.po_valid = valid_reg;
  assign bus.po_err   = err_reg;
  assign bus.busy     = (state_reg == RECV);

endmodule

// File: doc/sti_rx.md
Name: sti_rx

Overview:
- Receiving end of the STI serial link: captures the 1-bit so_data/so_valid stream produced by the STI transmitter and rebuilds the original 16-bit pi_data word.
- Frame configuration (pi_length, pi_msb, pi_low, pi_fill) uses the same encoding as the transmitter.
- Sits at the far end of the serial channel; feeds the data-arrangement/pixel-memory path or a loopback checker.

Parameters:
- None. Widths are fixed by the STI protocol: 16-bit payload, frames of 8/16/24/32 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- si_data  in  1  serial data bit (transmitter so_data)
- si_valid  in  1  serial bit qualifier (transmitter so_valid)
- cfg_length  in  2  00=8, 01=16, 10=24, 11=32 bits
- cfg_msb  in  1  1=MSB sent first, 0=LSB first
- cfg_low  in  1  8-bit frames only: 1=payload is the high byte, 0=payload is the low byte
- cfg_fill  in  1  24/32-bit frames: 1=payload in the top 16 bits, 0=payload in the bottom 16 bits
- po_data  out  16  reconstructed pi_data
- po_valid  out  1  one-cycle strobe, po_data valid
- po_err  out  1  one-cycle strobe, frame truncated
- busy  out  1  frame in progress

Behaviour:
- Reset (async, active-low): all outputs 0, state IDLE, bit counter 0, shift register 0.
- A bit is accepted on a rising clk edge with si_valid=1.
- IDLE:
  - Accepted bit starts a frame. cfg_* is latched from that same edge and held for the whole frame; cfg changes mid-frame are ignored.
  - Store the first bit, counter=1, go to RECV, busy=1.
- RECV:
  - Each accepted bit is shifted into a 32-bit register and the counter increments.
  - When the counter reaches N (8/16/24/32), the edge that samples bit N:
    - registers po_data, pulses po_valid for one cycle, returns to IDLE.
    - po_valid is high in the cycle after the last bit (latency 1).
- Back-to-back frames:
  - If si_valid stays high after bit N, the next bit starts a new frame with no idle cycle.
  - cfg_* is re-latched on that bit's edge.
  - From IDLE, that bit is taken in the same edge that ends the prior frame's strobe cycle; there is no lost bit.
- Truncation:
  - si_valid=0 in RECV with counter < N: pulse po_err for one cycle, discard the frame, go to IDLE.
  - po_data keeps its previous value; po_valid stays 0.
- Bit ordering:
  - Form W = N-bit word, MSB-first.
  - cfg_msb=1: W is the shift order.
  - cfg_msb=0: the bit received first becomes W[0].
- Extraction (unused byte forced to 0):
  - 8-bit, low=1: po_data={W[7:0],8'h00}.
  - 8-bit, low=0: po_data={8'h00,W[7:0]}.
  - 16-bit: po_data=W[15:0].
  - 24-bit: fill=1 → W[23:8]; fill=0 → W[15:0].
  - 32-bit: fill=1 → W[31:16]; fill=0 → W[15:0].
- busy: 1 in RECV, 0 in IDLE.
- Reset asserted mid-frame: immediate abort, no po_err, outputs 0.

Optional Feature:
- Macro: STI_RX_PADCHECK_EN.
- Defined:
  - Pad bits of 24/32-bit frames (the 8/16 bits not selected by cfg_fill) are checked for zero.
  - Any nonzero pad bit asserts po_err in the same cycle as po_valid; the data is still delivered.
- Undefined:
  - Pad bits are ignored.
  - po_err only indicates truncation.

Test Plan:
- 16-bit, msb=1, stream 0xA53C MSB-first with si_valid high for 16 cycles → po_valid one cycle after bit 16, po_data=0xA53C, po_err=0.
- 8-bit, msb=0, low=1, bits of 0x81 LSB-first → po_data=0x8100. Same with low=0 → po_data=0x0081.
- 32-bit, fill=0, msb=1, 0x0000BEEF, immediately followed by a 24-bit, fill=1, msb=0 frame carrying 0x1234 (W=0x123400) → two po_valid strobes, po_data=0xBEEF then 0x1234, no gap cycle.
- 24-bit frame, si_valid drops after 10 bits → po_err pulse, no po_valid, po_data unchanged, busy=0; next full 16-bit frame of 0x5555 decodes correctly.
- reset low after 5 bits of a 16-bit frame, released, full frame of 0x0F0F sent → no strobes during reset, then po_data=0x0F0F.
- STI_RX_PADCHECK_EN defined: 32-bit, fill=1, W=0xCAFE0001 → po_data=0xCAFE with po_valid=1 and po_err=1 in the same cycle. Macro undefined: po_err=0.
